mod_n_down_timer: RTL and testbench

//   Loadable down-counting timer: the counterpart of the free-running mod-M
//   up-counter. Software/FSM loads a terminal value, starts it, and the block

---
 rtl/mod_n_down_timer_if.sv | 24 ++
 rtl/mod_n_down_timer.sv | 75 +++++++
 tb/tb_mod_n_down_timer.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mod_n_down_timer_if.sv
// rtl/mod_n_down_timer_if.sv - control/status bundle for the loadable down-counting timer
interface mod_n_down_timer_if #(
  parameter int N = 8
);
  logic         en;
  logic         load;
  logic [N-1:0] load_val;
  logic         start;
  logic         mode;
  logic [N-1:0] count;
  logic         zero_tick;
  logic         busy;
  logic         done;

  modport master (
    output en, load, load_val, start, mode,
    input  count, zero_tick, busy, done
  );

  modport slave (
    input  en, load, load_val, start, mode,
    output count, zero_tick, busy, done
  );
endinterface

// File: rtl/mod_n_down_timer.sv
// rtl/mod_n_down_timer.sv - loadable one-shot/periodic down-counting timer with expiry pulse
module mod_n_down_timer #(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  mod_n_down_timer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [N-1:0] ONE  = N'(1);
  localparam logic [N-1:0] ZERO = '0;

  state_t       state,      state_nxt;
  logic [N-1:0] count_q,    count_nxt;
  logic [N-1:0] reload_q,   reload_nxt;
  logic         tick_q,     tick_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      count_q  <= ZERO;
      reload_q <= ZERO;
      tick_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      count_q  <= count_nxt;
      reload_q <= reload_nxt;
      tick_q   <= tick_nxt;
    end
  end

  // Priority is load > start > en; zero_tick is a pulse so it defaults low.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count_q;
    reload_nxt = reload_q;
    tick_nxt   = 1'b0;
    if (bus.load) begin
      reload_nxt = bus.load_val;
      count_nxt  = bus.load_val;
      state_nxt  = IDLE;
    end else if (bus.start) begin
      if (reload_q != ZERO) begin
        count_nxt = reload_q;
        state_nxt = RUN;
      end else begin
        count_nxt = ZERO;
        state_nxt = DONE;
        tick_nxt  = 1'b1;
      end
    end else if (state == RUN && bus.en) begin
      if (count_q > ONE) begin
        count_nxt = count_q - ONE;
      end else if (count_q == ONE) begin
        tick_nxt = 1'b1;
        if (bus.mode) begin
          count_nxt = reload_q;
        end else begin
          count_nxt = ZERO;
          state_nxt = DONE;
        end
      end
    end
  end

  assign bus.count     = count_q;
  assign bus.zero_tick = tick_q;
  assign bus.busy      = (state == RUN);
  assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_mod_n_down_timer.sv
// tb/tb_mod_n_down_timer.sv - scoreboard bench for mod_n_down_timer with directed vectors
module tb_mod_n_down_timer;
  logic clk;
  logic rst_n;

  mod_n_down_timer_if #(.N(8)) bus ();

  mod_n_down_timer #(.N(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] count;
    logic       tick;
    logic       busy;
    logic       done;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   fails  = 0;

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cyc(input logic r, input logic ld, input logic [7:0] lv,
                     input logic st, input logic e, input logic md,
                     input logic [7:0] ec, input logic et, input logic eb,
                     input logic ed, input string nm);
    exp_t x;
    @(negedge clk);
    rst_n        = r;
    bus.load     = ld;
    bus.load_val = lv;
    bus.start    = st;
    bus.en       = e;
    bus.mode     = md;
    x.count = ec;
    x.tick  = et;
    x.busy  = eb;
    x.done  = ed;
    x.name  = nm;
    exp_q.push_back(x);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.count !== e.count || bus.zero_tick !== e.tick ||
            bus.busy !== e.busy || bus.done !== e.done) begin
          fails++;
          $display("FAIL %s: got count=%0d tick=%0b busy=%0b done=%0b, expected count=%0d tick=%0b busy=%0b done=%0b",
                   e.name, bus.count, bus.zero_tick, bus.busy, bus.done,
                   e.count, e.tick, e.busy, e.done);
        end
      end
    end
  end

  initial begin : stimulus
    rst_n        = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = 8'd0;
    bus.start    = 1'b0;
    bus.en       = 1'b0;
    bus.mode     = 1'b0;

    // reset dominates active load/start/en
    cyc(0, 1, 8'd7, 1, 1, 0,  8'd0, 0, 0, 0, "reset_a");
    cyc(0, 1, 8'd7, 1, 1, 0,  8'd0, 0, 0, 0, "reset_b");
    cyc(1, 0, 8'd0, 1, 0, 0,  8'd0, 1, 0, 1, "reset_reload_zero_start");
    cyc(1, 0, 8'd0, 0, 0, 0,  8'd0, 0, 0, 1, "done_sticky");

    // one-shot from 5
    cyc(1, 1, 8'd5, 0, 0, 0,  8'd5, 0, 0, 0, "os_load");
    cyc(1, 0, 8'd0, 1, 1, 0,  8'd5, 0, 1, 0, "os_start");
    cyc(1, 0, 8'd0, 0, 1, 0,  8'd4, 0, 1, 0, "os_4");
    cyc(1, 0, 8'd0, 0, 1, 0,  8'd3, 0, 1, 0, "os_3");
    cyc(1, 0, 8'd0, 0, 1, 0,  8'd2, 0, 1, 0, "os_2");
    cyc(1, 0, 8'd0, 0, 1, 0,  8'd1, 0, 1, 0, "os_1");
    cyc(1, 0, 8'd0, 0, 1, 0,  8'd0, 1, 0, 1, "os_expire");
    cyc(1, 0, 8'd0, 0, 1, 0,  8'd0, 0, 0, 1, "os_hold_zero");

    // periodic from 3, then mode switch to one-shot mid-run
    cyc(1, 1, 8'd3, 0, 0, 1,  8'd3, 0, 0, 0, "per_load");
    cyc(1, 0, 8'd0, 1, 0, 1,  8'd3, 0, 1, 0, "per_start");
    cyc(1, 0, 8'd0, 0, 1, 1,  8'd2, 0, 1, 0, "per_2a");
    cyc(1, 0, 8'd0, 0, 1, 1,  8'd1, 0, 1, 0, "per_1a");
    cyc(1, 0, 8'd0, 0, 1, 1,  8'd3, 1, 1, 0, "per_reload_a");
    cyc(1, 0, 8'd0, 0, 1, 1,  8'd2, 0, 1, 0, "per_2b");
    cyc(1, 0, 8'd0, 0, 1, 1,  8'd1, 0, 1, 0, "per_1b");
    cyc(1, 0, 8'd0, 0, 1, 1,  8'd3, 1, 1, 0, "per_reload_b");
    cyc(1, 0, 8'd0, 0, 1, 1,  8'd2, 0, 1, 0, "per_2c");
    cyc(1, 0, 8'd0, 0, 1, 0,  8'd1, 0, 1, 0, "mode_sw_1");
    cyc(1, 0, 8'd0, 0, 1, 0,  8'd0, 1, 0, 1, "mode_sw_expire");

    // periodic with reload 1 ticks every enabled cycle
    cyc(1, 1, 8'd1, 0, 0, 1,  8'd1, 0, 0, 0, "r1_load");
    cyc(1, 0, 8'd0, 1, 0, 1,  8'd1, 0, 1, 0, "r1_start");
    for (int i = 0; i < 3; i++)
      cyc(1, 0, 8'd0, 0, 1, 1, 8'd1, 1, 1, 0, "r1_tick");
    cyc(1, 0, 8'd0, 0, 0, 1,  8'd1, 0, 1, 0, "r1_en_low");

    // enable gating, en one cycle in four
    cyc(1, 1, 8'd4, 0, 0, 0,  8'd4, 0, 0, 0, "gate_load");
    cyc(1, 0, 8'd0, 1, 0, 0,  8'd4, 0, 1, 0, "gate_start");
    for (int k = 0; k < 4; k++) begin
      cyc(1, 0, 8'd0, 0, 1, 0, (k < 3) ? 8'(3 - k) : 8'd0, (k == 3),
          (k < 3), (k == 3), "gate_en");
      for (int j = 0; j < 3; j++)
        cyc(1, 0, 8'd0, 0, 0, 0, (k < 3) ? 8'(3 - k) : 8'd0, 1'b0,
            (k < 3), (k == 3), "gate_hold");
    end

    // abort and priority
    cyc(1, 1, 8'd6, 0, 0, 0,  8'd6, 0, 0, 0, "ab_load");
    cyc(1, 0, 8'd0, 1, 0, 0,  8'd6, 0, 1, 0, "ab_start");
    cyc(1, 0, 8'd0, 0, 1, 0,  8'd5, 0, 1, 0, "ab_5");
    cyc(1, 0, 8'd0, 0, 1, 0,  8'd4, 0, 1, 0, "ab_4");
    cyc(1, 1, 8'd9, 0, 1, 0,  8'd9, 0, 0, 0, "ab_load_mid_run");
    cyc(1, 0, 8'd0, 0, 1, 0,  8'd9, 0, 0, 0, "idle_ignores_en");
    cyc(1, 0, 8'd2, 0, 1, 0,  8'd9, 0, 0, 0, "load_val_no_load");
    cyc(1, 1, 8'd7, 1, 0, 0,  8'd7, 0, 0, 0, "load_beats_start");
    cyc(1, 0, 8'd0, 1, 0, 0,  8'd7, 0, 1, 0, "pr_start");
    cyc(1, 0, 8'd0, 0, 1, 0,  8'd6, 0, 1, 0, "pr_6");
    cyc(1, 0, 8'd0, 0, 1, 0,  8'd5, 0, 1, 0, "pr_5");
    cyc(1, 0, 8'd0, 1, 1, 0,  8'd7, 0, 1, 0, "restart_in_run");
    cyc(1, 0, 8'd0, 0, 1, 0,  8'd6, 0, 1, 0, "restart_6");

    // reset mid-run at count 2
    cyc(1, 0, 8'd0, 0, 1, 0,  8'd5, 0, 1, 0, "mr_5");
    cyc(1, 0, 8'd0, 0, 1, 0,  8'd4, 0, 1, 0, "mr_4");
    cyc(1, 0, 8'd0, 0, 1, 0,  8'd3, 0, 1, 0, "mr_3");
    cyc(1, 0, 8'd0, 0, 1, 0,  8'd2, 0, 1, 0, "mr_2");
    cyc(0, 0, 8'd0, 0, 1, 0,  8'd0, 0, 0, 0, "mr_reset");
    cyc(1, 0, 8'd0, 1, 0, 0,  8'd0, 1, 0, 1, "mr_start_zero_reload");
    cyc(1, 0, 8'd0, 0, 0, 0,  8'd0, 0, 0, 1, "mr_single_tick");

    // explicit load of 0 then start
    cyc(1, 1, 8'd0, 0, 0, 0,  8'd0, 0, 0, 0, "z_load");
    cyc(1, 0, 8'd0, 1, 0, 0,  8'd0, 1, 0, 1, "z_start");
    cyc(1, 0, 8'd0, 0, 1, 0,  8'd0, 0, 0, 1, "z_no_second_tick");

    for (int w = 0; w < 4 && exp_q.size() != 0; w++) begin
      @(posedge clk);
      #2;
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected samples left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
